phase_ctrl_mpsk: RTL
====================

PHASE_CTRL_MPSK -- requirements
Module: phase_ctrl_mpsk

Interface
REQ-001 Parameters (name, default, meaning): DATA_WIDTH 8, RAM word width; ADDR_WIDTH 8, RAM address width; FRAME_LENGTH 150, words per frame; REF_CLK_FREQ 128000000, clk frequency in Hz; BAUDRATE 9600, symbols per second; BITS_PER_SYM 1, bits per symbol (1 = BPSK, 2 = QPSK).
REQ-002 Ports (name, direction, width, meaning): clk in 1, sole clock; rst_n in 1, reset, asynchronous, active-low.
REQ-003 start in 1, pulse that begins a frame; stop in 1, level that aborts at the next symbol boundary; continuous in 1, repeat the frame with no gap.
REQ-004 busy out 1, block is not IDLE; gen_en out 1, equals busy; sym_strobe out 1, one-cycle pulse on each symbol update; frame_done out 1, one-cycle pulse at the end of each frame.
REQ-005 phase_ctrl out BITS_PER_SYM, phase selector to the carrier generator.
REQ-006 RAM ports: ram_clk out 1, equals clk; ram_en out 1; ram_addr out ADDR_WIDTH; ram_rd_data in DATA_WIDTH, read data with 1-cycle read latency; ram_we out 1, tied to 0; ram_wr_data out DATA_WIDTH, tied to 0; ram_rst out 1, tied to 0.

Function
REQ-007 CYCLE SHALL equal REF_CLK_FREQ/BAUDRATE, integer division; SYMS = DATA_WIDTH/BITS_PER_SYM; elaboration SHALL fail if CYCLE<4, if DATA_WIDTH mod BITS_PER_SYM != 0, or if BITS_PER_SYM is not 1 or 2.
REQ-008 FSM states SHALL be IDLE, FETCH, LATCH, SYMBOL, WAIT.
REQ-009 IDLE->FETCH on start=1; start SHALL be ignored outside IDLE.
REQ-010 FETCH: ram_en=1 and ram_addr presented for exactly 1 cycle; FETCH->LATCH.
REQ-011 LATCH: ram_rd_data loaded into the shift register; LATCH->SYMBOL.
REQ-012 SYMBOL: lasts 1 cycle; outputs the MSB-first BITS_PER_SYM slice; sym_strobe=1; SYMBOL->WAIT.
REQ-013 WAIT: cycle counter runs; on reaching CYCLE-1 since the last SYMBOL, WAIT->SYMBOL, so consecutive sym_strobe pulses are exactly CYCLE clocks apart.
REQ-014 The next word SHALL be prefetched in WAIT: ram_en is pulsed in the cycle after the SYMBOL that outputs a word's last symbol, and the data is captured 1 cycle later into a pending register. There SHALL be no symbol gap at word boundaries.
REQ-015 ram_addr SHALL increment once per word fetched; it wraps FRAME_LENGTH-1 -> 0.
REQ-016 End of frame (the last symbol period of word FRAME_LENGTH-1 expires): frame_done pulses for 1 cycle in the cycle that would have been SYMBOL.
REQ-017 At end of frame with continuous=1: that cycle is SYMBOL for word 0 instead, with no gap, and frame_done is still pulsed.
REQ-018 At end of frame with continuous=0: the FSM goes to IDLE and ram_addr returns to 0.
REQ-019 stop=1, sampled at a symbol boundary: the FSM enters IDLE instead of SYMBOL, no frame_done is pulsed, ram_addr returns to 0, and phase_ctrl holds its value.
REQ-020 If stop and end of frame coincide, stop SHALL win.
REQ-021 phase_ctrl SHALL change only in SYMBOL and SHALL hold in every other state.
REQ-022 busy=0 in IDLE only.

Reset
REQ-023 rst_n=0 SHALL force, asynchronously: state=IDLE; phase_ctrl=0, busy=0, gen_en=0, sym_strobe=0, frame_done=0; ram_en=0, ram_addr=0; counters=0; shift and pending registers=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no frame_done pulse; after release, a new start replays from word 0.

Configuration
REQ-025 Macro PHASE_CTRL_DIFF_EN defined: differential encoding, phase_ctrl <= phase_ctrl + sym mod 2^BITS_PER_SYM (BPSK: toggle on 1, i.e. NRZ-M).
REQ-026 PHASE_CTRL_DIFF_EN undefined: absolute mapping, phase_ctrl <= sym.

Structure
REQ-027 A shared package phase_ctrl_pkg SHALL hold the FSM state typedef/encoding and the CYCLE/SYMS derivation helpers.
REQ-028 The symbol timer SHALL be a sub-module, baud_timer, with a counter, a load input and a terminal-count output; everything else stays in phase_ctrl_mpsk.

Verification (REF_CLK_FREQ=16, BAUDRATE=2 -> CYCLE=8; FRAME_LENGTH=2)
REQ-029 BPSK with DIFF_EN, RAM={8'hA5, 8'h00}, start -> 16 sym_strobe pulses 8 clocks apart; phase_ctrl sequence 1,1,0,0,0,1,1,0 then held for the next 8 symbols; frame_done 8 clocks after the 16th strobe; then IDLE.
REQ-030 QPSK without DIFF_EN, RAM={8'h1B, 8'hE4} -> phase_ctrl 0,1,2,3,3,2,1,0.
REQ-031 continuous=1, two frames -> sym_strobe spacing stays exactly 8 across the wrap; ram_addr sequence 0,1,0,1; frame_done pulses twice.
REQ-032 stop asserted during symbol 5 -> IDLE at the next boundary; no frame_done; phase_ctrl holds; ram_addr=0.
REQ-033 rst_n pulsed low mid-frame -> all outputs at reset values immediately; a following start replays from word 0.
REQ-034 start pulsed while busy -> no effect on timing or address.

Source files
------------

// File: rtl/phase_ctrl_pkg.sv
// Shared state encoding and parameter derivation helpers for the MPSK phase controller.
package phase_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LATCH  = 3'd2,
        SYMBOL = 3'd3,
        WAIT   = 3'd4
    } state_t;

    function automatic int calc_cycle(input int ref_clk_freq, input int baudrate);
        return ref_clk_freq / baudrate;
    endfunction

    function automatic int calc_syms(input int data_width, input int bits_per_sym);
        return data_width / bits_per_sym;
    endfunction

endpackage

// File: rtl/baud_timer.sv
// Symbol period down-counter: load restarts the period, tc flags its last clock.
module baud_timer #(
    parameter int LOAD_VAL = 6,
    parameter int CNT_W    = (LOAD_VAL < 2) ? 1 : $clog2(LOAD_VAL + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(LOAD_VAL);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/phase_ctrl_mpsk.sv
// Streams RAM words out as BPSK/QPSK phase selections, one symbol per baud period.
// Define PHASE_CTRL_DIFF_EN for differential phase encoding; absolute mapping otherwise.
//
// state  | meaning
// IDLE   | waiting for start, outputs quiet, address parked at 0
// FETCH  | first word of the frame requested from RAM
// LATCH  | first word arrives and is loaded into the shift register
// SYMBOL | one-cycle symbol update, sym_strobe high
// WAIT   | baud period runs out, next word prefetched after the last symbol
module phase_ctrl_mpsk
    import phase_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int FRAME_LENGTH = 150,
    parameter int REF_CLK_FREQ = 128000000,
    parameter int BAUDRATE     = 9600,
    parameter int BITS_PER_SYM = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    continuous,
    output logic                    busy,
    output logic                    gen_en,
    output logic                    sym_strobe,
    output logic                    frame_done,
    output logic [BITS_PER_SYM-1:0] phase_ctrl,
    output logic                    ram_clk,
    output logic                    ram_en,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    input  logic [DATA_WIDTH-1:0]   ram_rd_data,
    output logic                    ram_we,
    output logic [DATA_WIDTH-1:0]   ram_wr_data,
    output logic                    ram_rst
);

    localparam int CYCLE = calc_cycle(REF_CLK_FREQ, BAUDRATE);
    localparam int SYMS  = calc_syms(DATA_WIDTH, BITS_PER_SYM);
    localparam int SYM_W = (SYMS < 2) ? 1 : $clog2(SYMS);

    if (CYCLE < 4) begin : g_bad_cycle
        $error("phase_ctrl_mpsk: REF_CLK_FREQ/BAUDRATE must be at least 4");
    end
    if (DATA_WIDTH % BITS_PER_SYM != 0) begin : g_bad_width
        $error("phase_ctrl_mpsk: DATA_WIDTH must be a multiple of BITS_PER_SYM");
    end
    if (BITS_PER_SYM != 1 && BITS_PER_SYM != 2) begin : g_bad_bps
        $error("phase_ctrl_mpsk: BITS_PER_SYM must be 1 or 2");
    end

    state_t                  state;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [DATA_WIDTH-1:0]   pend_q;
    logic [SYM_W-1:0]        sym_cnt;
    logic [ADDR_WIDTH-1:0]   word_cnt;
    logic                    fetch_d;
    logic                    timer_load;
    logic                    tc;
    logic                    last_sym;
    logic                    last_word;
    logic [DATA_WIDTH-1:0]   src_word;
    logic [DATA_WIDTH-1:0]   src_shifted;
    logic [BITS_PER_SYM-1:0] sym_new;
    logic [BITS_PER_SYM-1:0] phase_next;

    assign timer_load = (state == SYMBOL);

    baud_timer #(
        .LOAD_VAL (CYCLE - 2)
    ) u_baud_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (timer_load),
        .tc    (tc)
    );

    assign last_sym  = (sym_cnt == SYM_W'(SYMS - 1));
    assign last_word = (word_cnt == ADDR_WIDTH'(FRAME_LENGTH - 1));

    // The word feeding the next symbol: fresh RAM data on the first symbol,
    // the prefetched word at a word boundary, otherwise the shift register.
    always_comb begin
        src_word = shift_q;
        if (state == LATCH) begin
            src_word = ram_rd_data;
        end else if (last_sym) begin
            src_word = pend_q;
        end
    end

    assign sym_new     = src_word[DATA_WIDTH-1 -: BITS_PER_SYM];
    assign src_shifted = src_word << BITS_PER_SYM;

`ifdef PHASE_CTRL_DIFF_EN
    assign phase_next = phase_ctrl + sym_new;
`else
    assign phase_next = sym_new;
`endif

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        return (a == ADDR_WIDTH'(FRAME_LENGTH - 1)) ? '0 : a + ADDR_WIDTH'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            phase_ctrl <= '0;
            busy       <= 1'b0;
            sym_strobe <= 1'b0;
            frame_done <= 1'b0;
            ram_en     <= 1'b0;
            ram_addr   <= '0;
            shift_q    <= '0;
            pend_q     <= '0;
            sym_cnt    <= '0;
            word_cnt   <= '0;
            fetch_d    <= 1'b0;
        end else begin
            sym_strobe <= 1'b0;
            frame_done <= 1'b0;
            ram_en     <= 1'b0;
            fetch_d    <= ram_en && (state == WAIT);
            if (ram_en) begin
                ram_addr <= next_addr(ram_addr);
            end
            if (fetch_d) begin
                pend_q <= ram_rd_data;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= FETCH;
                        busy   <= 1'b1;
                        ram_en <= 1'b1;
                    end
                end
                FETCH: begin
                    state <= LATCH;
                end
                LATCH: begin
                    state      <= SYMBOL;
                    sym_strobe <= 1'b1;
                    phase_ctrl <= phase_next;
                    shift_q    <= src_shifted;
                    sym_cnt    <= '0;
                end
                SYMBOL: begin
                    state <= WAIT;
                    if (last_sym) begin
                        ram_en <= 1'b1;
                    end
                end
                WAIT: begin
                    if (tc) begin
                        if (stop) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            ram_addr <= '0;
                            word_cnt <= '0;
                        end else if (last_sym && last_word && !continuous) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            ram_addr   <= '0;
                            word_cnt   <= '0;
                        end else begin
                            state      <= SYMBOL;
                            sym_strobe <= 1'b1;
                            phase_ctrl <= phase_next;
                            shift_q    <= src_shifted;
                            if (last_sym) begin
                                sym_cnt    <= '0;
                                word_cnt   <= last_word ? '0 : word_cnt + ADDR_WIDTH'(1);
                                frame_done <= last_word;
                            end else begin
                                sym_cnt <= sym_cnt + SYM_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gen_en      = busy;
    assign ram_clk     = clk;
    assign ram_we      = 1'b0;
    assign ram_wr_data = '0;
    assign ram_rst     = 1'b0;

endmodule
